// File: rtl/intr_arb.sv
// Interrupt priority arbiter: picks the highest-level qualified device request and runs the CPU acknowledge handshake.
// Latency: interrupt rises one cycle after the request is first sampled; the acked device gets a one-cycle dev_ack.
module intr_arb #(
    parameter int NDEV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NDEV-1:0]      dev_irq,
    input  logic [3*NDEV-1:0]    dev_ipl,
    input  logic [8*NDEV-1:0]    dev_vector,
    input  logic [2:0]           cpu_ipl,
    input  logic                 int_ack,
    output logic                 interrupt,
    output logic [7:0]           interrupt_ipl,
    output logic [7:0]           vector,
    output logic [NDEV-1:0]      dev_ack,
    output logic                 busy
);

    localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;

    typedef enum logic [1:0] {IDLE, PEND, ACK, WREL} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   win_q, win_nxt, best_idx;
    logic [2:0]      lvl_q, lvl_nxt, best_lvl;
    logic [7:0]      vec_q, vec_nxt;
    logic            found;

    // Strict '>' while scanning upward keeps the lowest index on a level tie.
    always_comb begin
        best_idx = '0;
        best_lvl = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (dev_irq[i] && (dev_ipl[3*i +: 3] > cpu_ipl) && (dev_ipl[3*i +: 3] > best_lvl)) begin
                best_idx = IW'(i);
                best_lvl = dev_ipl[3*i +: 3];
            end
        end
        found = (best_lvl != 3'd0);
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win_q;
        lvl_nxt   = lvl_q;
        vec_nxt   = vec_q;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = PEND;
                    win_nxt   = best_idx;
                    lvl_nxt   = best_lvl;
                    vec_nxt   = dev_vector[8*best_idx +: 8];
                end
            end
            PEND: begin
                if (int_ack) begin
                    state_nxt = ACK;
                end else if (!dev_irq[win_q] || (cpu_ipl >= lvl_q)) begin
                    state_nxt = IDLE;
                end else if (found && (best_lvl > lvl_q)) begin
                    win_nxt = best_idx;
                    lvl_nxt = best_lvl;
                    vec_nxt = dev_vector[8*best_idx +: 8];
                end
            end
            ACK: begin
                state_nxt = WREL;
            end
            WREL: begin
                if (!int_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            win_q <= '0;
            lvl_q <= '0;
            vec_q <= '0;
        end else begin
            state <= state_nxt;
            win_q <= win_nxt;
            lvl_q <= lvl_nxt;
            vec_q <= vec_nxt;
        end
    end

    // Level 0 never wins, so a cleared level doubles as "no one-hot bit".
    assign interrupt_ipl = (lvl_q == 3'd0) ? 8'h00 : (8'h01 << lvl_q);
    assign interrupt     = (state == PEND);
    assign vector        = vec_q;
    assign busy          = (state != IDLE);

    always_comb begin
        dev_ack = '0;
        if (state == ACK) begin
            dev_ack[win_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_intr_arb.sv
// Bench for intr_arb: directed vector table, async reset sequence, then random traffic against a reference model.
module tb_intr_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  dev_irq = '0;
    logic [11:0] dev_ipl = '0;
    logic [31:0] dev_vector = '0;
    logic [2:0]  cpu_ipl = '0;
    logic        int_ack = 1'b0;
    logic        interrupt;
    logic [7:0]  interrupt_ipl;
    logic [7:0]  vector;
    logic [3:0]  dev_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    intr_arb #(.NDEV(4)) dut (
        .clk(clk), .reset(reset), .dev_irq(dev_irq), .dev_ipl(dev_ipl),
        .dev_vector(dev_vector), .cpu_ipl(cpu_ipl), .int_ack(int_ack),
        .interrupt(interrupt), .interrupt_ipl(interrupt_ipl), .vector(vector),
        .dev_ack(dev_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  irq;
        logic [11:0] ipl;
        logic [31:0] vec;
        logic [2:0]  cpu;
        logic        ack;
        logic        e_int;
        logic [7:0]  e_ipl;
        logic [7:0]  e_vec;
        logic [3:0]  e_ack;
        logic        e_busy;
        logic        cv;
    } vec_t;

    vec_t tbl[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: phase 0=idle 1=pending 2=ack 3=wait-release.
    int       m_phase;
    int       m_win;
    int       m_lvl;
    bit [7:0] m_vec;

    // Search levels from the top down, devices from index 0 up.
    function automatic void ref_pick(input logic [3:0] irq, input logic [11:0] ipl, input logic [2:0] cpu,
                                     output bit f, output int idx, output int lvl);
        f = 0; idx = 0; lvl = 0;
        for (int l = 7; l > int'(cpu); l--) begin
            for (int d = 0; d < 4; d++) begin
                if (!f && irq[d] && int'((ipl >> (3*d)) & 12'h7) == l) begin
                    f = 1; idx = d; lvl = l;
                end
            end
        end
    endfunction

    task automatic model_step;
        bit f; int idx; int lvl;
        ref_pick(dev_irq, dev_ipl, cpu_ipl, f, idx, lvl);
        case (m_phase)
            0: if (f) begin
                   m_phase = 1; m_win = idx; m_lvl = lvl; m_vec = dev_vector[8*idx +: 8];
               end
            1: if (int_ack) m_phase = 2;
               else if (!dev_irq[m_win] || int'(cpu_ipl) >= m_lvl) m_phase = 0;
               else if (f && lvl > m_lvl) begin
                   m_win = idx; m_lvl = lvl; m_vec = dev_vector[8*idx +: 8];
               end
            2: m_phase = 3;
            default: if (!int_ack) m_phase = 0;
        endcase
    endtask

    initial begin
        //            rst  irq    ipl      vec            cpu   ack   int   ipl    vec    ack    busy  cv
        tbl[0]  = '{1'b1, 4'h0, 12'h000, 32'h00000000, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 4'h4, 12'h140, 32'h00900000, 3'd0, 1'b0, 1'b1, 8'h20, 8'h90, 4'h0, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 4'h4, 12'h140, 32'h00900000, 3'd0, 1'b1, 1'b0, 8'h20, 8'h90, 4'h4, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 4'h0, 12'h140, 32'h00900000, 3'd0, 1'b1, 1'b0, 8'h20, 8'h90, 4'h0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 4'h0, 12'h140, 32'h00900000, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 12'hBB4, 32'h40302010, 3'd0, 1'b0, 1'b1, 8'h40, 8'h20, 4'h0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 4'hF, 12'hBB4, 32'h40302010, 3'd0, 1'b1, 1'b0, 8'h40, 8'h20, 4'h2, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 4'hD, 12'hBB4, 32'h40302010, 3'd0, 1'b1, 1'b0, 8'h40, 8'h20, 4'h0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 4'hD, 12'hBB4, 32'h40302010, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'hD, 12'hBB4, 32'h40302010, 3'd0, 1'b0, 1'b1, 8'h40, 8'h30, 4'h0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 4'hD, 12'hBB4, 32'h40302010, 3'd0, 1'b1, 1'b0, 8'h40, 8'h30, 4'h4, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 4'h0, 12'hBB4, 32'h40302010, 3'd0, 1'b0, 1'b0, 8'h40, 8'h30, 4'h0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 4'h0, 12'hBB4, 32'h40302010, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'h1, 12'h004, 32'h00000044, 3'd4, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 4'h1, 12'h004, 32'h00000044, 3'd3, 1'b0, 1'b1, 8'h10, 8'h44, 4'h0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 4'h1, 12'h004, 32'h00000044, 3'd4, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 4'h1, 12'h004, 32'h00000044, 3'd4, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 4'h8, 12'h800, 32'h3300000C, 3'd0, 1'b0, 1'b1, 8'h10, 8'h33, 4'h0, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 4'h9, 12'h806, 32'h3300000C, 3'd0, 1'b0, 1'b1, 8'h40, 8'h0C, 4'h0, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 4'h0, 12'h806, 32'h3300000C, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 4'h8, 12'h800, 32'h3300000C, 3'd0, 1'b0, 1'b1, 8'h10, 8'h33, 4'h0, 1'b1, 1'b1};
        tbl[21] = '{1'b0, 4'h9, 12'h804, 32'h3300000C, 3'd0, 1'b0, 1'b1, 8'h10, 8'h33, 4'h0, 1'b1, 1'b1};
        tbl[22] = '{1'b0, 4'h1, 12'h806, 32'h3300000C, 3'd0, 1'b1, 1'b0, 8'h10, 8'h33, 4'h8, 1'b1, 1'b1};
        tbl[23] = '{1'b0, 4'h0, 12'h806, 32'h3300000C, 3'd0, 1'b0, 1'b0, 8'h10, 8'h33, 4'h0, 1'b1, 1'b1};
        tbl[24] = '{1'b0, 4'h0, 12'h806, 32'h3300000C, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0};

        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            reset = tbl[k].rst; dev_irq = tbl[k].irq; dev_ipl = tbl[k].ipl;
            dev_vector = tbl[k].vec; cpu_ipl = tbl[k].cpu; int_ack = tbl[k].ack;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d interrupt", k), 32'(interrupt), 32'(tbl[k].e_int));
            chk($sformatf("row%0d dev_ack", k), 32'(dev_ack), 32'(tbl[k].e_ack));
            chk($sformatf("row%0d busy", k), 32'(busy), 32'(tbl[k].e_busy));
            if (tbl[k].cv) begin
                chk($sformatf("row%0d interrupt_ipl", k), 32'(interrupt_ipl), 32'(tbl[k].e_ipl));
                chk($sformatf("row%0d vector", k), 32'(vector), 32'(tbl[k].e_vec));
            end
        end

        // Async reset while waiting for int_ack to drop.
        @(negedge clk);
        dev_irq = 4'h4; dev_ipl = 12'h140; dev_vector = 32'h00900000; cpu_ipl = 3'd0; int_ack = 1'b0;
        @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        dev_irq = 4'h0;
        @(posedge clk);
        #1;
        chk("wrel busy", 32'(busy), 32'd1);
        chk("wrel dev_ack", 32'(dev_ack), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst interrupt", 32'(interrupt), 32'd0);
        chk("arst interrupt_ipl", 32'(interrupt_ipl), 32'd0);
        chk("arst vector", 32'(vector), 32'd0);
        chk("arst dev_ack", 32'(dev_ack), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("post-reset dev_ack", 32'(dev_ack), 32'd0);
            chk("post-reset busy", 32'(busy), 32'd0);
        end

        // Random traffic against the model.
        m_phase = 0; m_win = 0; m_lvl = 0; m_vec = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            dev_irq    = 4'($urandom);
            dev_ipl    = 12'($urandom);
            dev_vector = $urandom;
            cpu_ipl    = 3'($urandom_range(0, 5));
            int_ack    = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            model_step();
            #1;
            chk("rand interrupt", 32'(interrupt), 32'(m_phase == 1));
            chk("rand busy", 32'(busy), 32'(m_phase != 0));
            chk("rand dev_ack", 32'(dev_ack), (m_phase == 2) ? (32'd1 << m_win) : 32'd0);
            if (m_phase != 0) begin
                chk("rand interrupt_ipl", 32'(interrupt_ipl), 32'd1 << m_lvl);
                chk("rand vector", 32'(vector), 32'(m_vec));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
